// File: rtl/vr_pkg.sv
// rtl/vr_pkg.sv - shared write-port operation encodings for the register bank
package vr_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_HOLD = 2'b00;
    localparam op_t OP_LOAD = 2'b01;
    localparam op_t OP_INC  = 2'b10;
    localparam op_t OP_CLR  = 2'b11;

endpackage

// File: rtl/register_bank_next.sv
// rtl/register_bank_next.sv - next-value logic for one entry under a write-port op
module register_bank_next
    import vr_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] cur_value,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] next_value,
    output logic                  wrap
);

    always_comb begin
        next_value = cur_value;
        wrap       = 1'b0;
        case (op)
            OP_LOAD: next_value = data_in;
            OP_INC: begin
                next_value = cur_value + DATA_WIDTH'(1);
                wrap       = &cur_value;
            end
            OP_CLR:  next_value = '0;
            default: next_value = cur_value;
        endcase
    end

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - register bank with load/inc/clear write port and two registered read ports
module register_bank
    import vr_pkg::*;
#(
    parameter int                       DATA_WIDTH  = 8,
    parameter int                       ADDR_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0,
    parameter int                       BYPASS      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  op,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        clear_all,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_b,
    output logic [DATA_WIDTH-1:0]       data_out_a,
    output logic [DATA_WIDTH-1:0]       data_out_b,
    output logic [2**ADDR_WIDTH-1:0]    valid,
    output logic                        inc_wrap
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_next;
    logic                  wr_wrap;
    logic [DATA_WIDTH-1:0] rd_a_next;
    logic [DATA_WIDTH-1:0] rd_b_next;

    register_bank_next #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next (
        .op         (op),
        .cur_value  (mem[wr_addr]),
        .data_in    (data_in),
        .next_value (wr_next),
        .wrap       (wr_wrap)
    );

    // A colliding read sees the same post-op value that is being written.
    always_comb begin
        rd_a_next = mem[rd_addr_a];
        rd_b_next = mem[rd_addr_b];
        if (BYPASS != 0 && op != OP_HOLD) begin
            if (rd_addr_a == wr_addr) rd_a_next = wr_next;
            if (rd_addr_b == wr_addr) rd_b_next = wr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VALUE;
            valid      <= '0;
            data_out_a <= '0;
            data_out_b <= '0;
            inc_wrap   <= 1'b0;
        end else if (clear_all) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid      <= '0;
            inc_wrap   <= 1'b0;
            data_out_a <= (BYPASS != 0) ? '0 : mem[rd_addr_a];
            data_out_b <= (BYPASS != 0) ? '0 : mem[rd_addr_b];
        end else begin
            mem[wr_addr] <= wr_next;
            case (op)
                OP_LOAD, OP_INC: valid[wr_addr] <= 1'b1;
                OP_CLR:          valid[wr_addr] <= 1'b0;
                default:         ;
            endcase
            inc_wrap   <= wr_wrap;
            data_out_a <= rd_a_next;
            data_out_b <= rd_b_next;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - randomized bench for register_bank against an array model, both bypass modes
module tb_register_bank;
    import vr_pkg::*;

    logic       clk = 1'b0;
    logic       run_clk = 1'b1;
    logic       rst = 1'b1;
    logic [1:0] op = OP_HOLD;
    logic [2:0] wr_addr = '0;
    logic [7:0] data_in = '0;
    logic       clear_all = 1'b0;
    logic [2:0] rd_addr_a = '0;
    logic [2:0] rd_addr_b = '0;

    logic [7:0] a1, b1, a0, b0;
    logic [7:0] valid1, valid0;
    logic       wrap1, wrap0;

    int checks = 0;
    int failures = 0;

    register_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RESET_VALUE(8'h00), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .op(op), .wr_addr(wr_addr), .data_in(data_in),
        .clear_all(clear_all), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .data_out_a(a1), .data_out_b(b1), .valid(valid1), .inc_wrap(wrap1)
    );

    register_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RESET_VALUE(8'h00), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .op(op), .wr_addr(wr_addr), .data_in(data_in),
        .clear_all(clear_all), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .data_out_a(a0), .data_out_b(b0), .valid(valid0), .inc_wrap(wrap0)
    );

    initial begin
        forever begin
            #5;
            if (run_clk) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: the bank is an array; bypass reads see the array after the write,
    // non-bypass reads see it before.
    logic [7:0] m_mem [8];
    logic [7:0] m_valid;
    logic [7:0] e_a1, e_b1, e_a0, e_b0;
    logic       e_wrap;
    logic       model_ready = 1'b0;

    always @(posedge clk) begin
        logic [7:0] pre [8];
        pre = m_mem;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_valid = '0;
            {e_a1, e_b1, e_a0, e_b0} = '0;
            e_wrap = 1'b0;
            model_ready = 1'b1;
        end else if (clear_all) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_valid = '0;
            e_wrap = 1'b0;
            e_a1 = 8'h00;
            e_b1 = 8'h00;
            e_a0 = pre[rd_addr_a];
            e_b0 = pre[rd_addr_b];
        end else begin
            e_wrap = (op == OP_INC) && (pre[wr_addr] == 8'hFF);
            if (op == OP_LOAD) begin
                m_mem[wr_addr] = data_in;
                m_valid[wr_addr] = 1'b1;
            end else if (op == OP_INC) begin
                m_mem[wr_addr] = 8'((int'(pre[wr_addr]) + 1) % 256);
                m_valid[wr_addr] = 1'b1;
            end else if (op == OP_CLR) begin
                m_mem[wr_addr] = 8'h00;
                m_valid[wr_addr] = 1'b0;
            end
            e_a1 = m_mem[rd_addr_a];
            e_b1 = m_mem[rd_addr_b];
            e_a0 = pre[rd_addr_a];
            e_b0 = pre[rd_addr_b];
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("byp_a", a1, e_a1);
            check("byp_b", b1, e_b1);
            check("nobyp_a", a0, e_a0);
            check("nobyp_b", b0, e_b0);
            check("valid_byp", valid1, m_valid);
            check("valid_nobyp", valid0, m_valid);
            check("wrap_byp", wrap1, e_wrap);
            check("wrap_nobyp", wrap0, e_wrap);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] o, input logic [2:0] wa, input logic [7:0] d,
                         input logic [2:0] ra, input logic [2:0] rb);
        op = o; wr_addr = wa; data_in = d; rd_addr_a = ra; rd_addr_b = rb;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // Reset discards in-flight load
        drive(OP_LOAD, 3'd2, 8'h55, 3'd2, 3'd2); tick();
        rst = 1'b1; drive(OP_LOAD, 3'd2, 8'hAA, 3'd2, 3'd2); tick();
        check("rst_a", a1, 8'h00);
        check("rst_valid", valid1, 8'h00);
        check("rst_wrap", wrap1, 1'b0);
        rst = 1'b0; drive(OP_HOLD, 3'd0, 8'h00, 3'd2, 3'd2); tick();
        check("rst_entry2", a1, 8'h00);

        // Load with same-cycle read, both bypass modes
        drive(OP_LOAD, 3'd3, 8'h55, 3'd3, 3'd0); tick();
        check("load_byp_a", a1, 8'h55);
        check("load_nobyp_a", a0, 8'h00);
        check("load_valid3", valid1[3], 1'b1);
        drive(OP_HOLD, 3'd0, 8'h00, 3'd3, 3'd0); tick();
        check("load_nobyp_a_later", a0, 8'h55);

        // Increment wrap
        drive(OP_LOAD, 3'd1, 8'hFE, 3'd1, 3'd1); tick();
        drive(OP_INC, 3'd1, 8'h00, 3'd1, 3'd1); tick();
        check("inc_ff", a1, 8'hFF);
        check("inc_nowrap", wrap1, 1'b0);
        drive(OP_INC, 3'd1, 8'h00, 3'd1, 3'd1); tick();
        check("inc_00", a1, 8'h00);
        check("inc_wrap", wrap1, 1'b1);
        drive(OP_LOAD, 3'd1, 8'h00, 3'd1, 3'd1); tick();
        check("wrap_pulse_end", wrap1, 1'b0);

        // Isolation and CLR
        drive(OP_LOAD, 3'd0, 8'h11, 3'd0, 3'd7); tick();
        drive(OP_LOAD, 3'd7, 8'h22, 3'd0, 3'd7); tick();
        drive(OP_CLR, 3'd0, 8'h00, 3'd0, 3'd7); tick();
        check("clr_a0", a1, 8'h00);
        check("clr_b7", b1, 8'h22);
        check("clr_valid0", valid1[0], 1'b0);
        check("clr_valid7", valid1[7], 1'b1);

        // clear_all beats op
        clear_all = 1'b1; drive(OP_LOAD, 3'd4, 8'h77, 3'd4, 3'd7); tick();
        clear_all = 1'b0;
        check("clrall_valid", valid1, 8'h00);
        check("clrall_a", a1, 8'h00);
        check("clrall_nobyp_b", b0, 8'h22);
        drive(OP_HOLD, 3'd0, 8'h00, 3'd4, 3'd7); tick();
        check("clrall_entry4", a1, 8'h00);

        // No edge, no change
        drive(OP_LOAD, 3'd5, 8'hAA, 3'd5, 3'd5); tick();
        check("pre_pause_a", a1, 8'hAA);
        run_clk = 1'b0;
        rst = 1'b1; drive(OP_LOAD, 3'd5, 8'h00, 3'd5, 3'd5);
        #12;
        check("no_edge_a", a1, 8'hAA);
        check("no_edge_valid5", valid1[5], 1'b1);
        rst = 1'b0; drive(OP_HOLD, 3'd5, 8'h00, 3'd5, 3'd5);
        run_clk = 1'b1;
        tick();
        check("post_pause_a", a1, 8'hAA);

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            clear_all = ($urandom_range(0, 31) == 0);
            drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
        end
        rst = 1'b0; clear_all = 1'b0;
        drive(OP_HOLD, 3'd0, 8'h00, 3'd0, 3'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
